dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: LATENCY, default 2, number of cycles from request acceptance edge to rsp_valid assertion; legal range 1..15.
REQ-002 Parameter: DEPTH_BYTES, default 512, byte capacity of the internal data array; address width is 9.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset asserted when low.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_rw  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_se  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  9  byte address.
REQ-011 req_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load result, extended per req_se; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or used reserved size.

Function
REQ-016 FSM states: IDLE, BUSY, RESP; a request is accepted only on a rising edge with req_valid=1 and req_ready=1.
REQ-017 req_ready shall be 1 only in IDLE; it is combinational from state, not from req_valid.
REQ-018 On acceptance, rw, size, se, addr and wdata are captured; later changes on req_* do not affect the transaction; the wait counter loads LATENCY-1.
REQ-019 IDLE->BUSY on acceptance; BUSY decrements the counter each cycle; BUSY->RESP on the edge where the counter is 0; rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 When LATENCY=1, IDLE->RESP is taken directly on acceptance.
REQ-021 The array access (load read or store write) occurs on the edge entering RESP; rsp_rdata and rsp_err are registered on that edge and held stable while in RESP.
REQ-022 RESP->IDLE on the edge with rsp_ready=1; rsp_valid deasserts in the cycle after; rsp_valid is held while rsp_ready=0, with no timeout.
REQ-023 The earliest next acceptance is the cycle after RESP->IDLE; req_valid during BUSY/RESP is ignored and not queued.
REQ-024 Byte order is big-endian: word at A occupies bytes A (bits 31:24) to A+3 (bits 7:0); halfword at A occupies A (15:8) and A+1 (7:0).
REQ-025 Misalignment rule: halfword with addr[0]=1 or word with addr[1:0]!=0 sets rsp_err=1; size 11 also sets rsp_err=1.
REQ-026 On an error, no array byte is written and rsp_rdata=0; timing is identical to a legal access.
REQ-027 Byte load returns byte in [7:0], and bits [31:8] are replicated bit 7 if se=1, else 0; halfword load follows the same rule with bit 15.
REQ-028 Stores write only the addressed 1/2/4 bytes; other bytes are unchanged; rsp_rdata=0 for stores.
REQ-029 Addresses do not wrap across the array end; aligned accesses never cross it.

Reset
REQ-030 Reset low, at any time: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset is low.
REQ-031 req_ready is 1 from the first cycle after reset deasserts.
REQ-032 Reset mid-transaction (BUSY or RESP) abandons it: a pending store not yet committed is not written, and no response is produced afterwards.
REQ-033 Array contents are not initialised by reset; the bench shall preload memory via stores before loading.

Verification
REQ-034 LATENCY=2: store word 0xDEADBEEF @0x010, then load word @0x010 -> rsp_valid rises 2 cycles after each acceptance, and load rsp_rdata=0xDEADBEEF with rsp_err=0.
REQ-035 Load byte @0x011 se=1 -> 0xFFFFFFAD; se=0 -> 0x000000AD; load halfword @0x012 se=1 -> 0xFFFFBEEF.
REQ-036 Store byte 0x12 @0x013, then load word @0x010 -> 0xDEADBE12, showing the other bytes are untouched.
REQ-037 Store word @0x011, and separately load halfword @0x013 -> rsp_err=1, rsp_rdata=0, and the word @0x010 is unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid -> rsp_valid and rsp_rdata are stable, req_ready=0, and nothing is accepted; after rsp_ready=1, req_ready=1 the next cycle.
REQ-039 Assert reset low during BUSY of store 0x0 @0x020 that follows an earlier store 0x55AA55AA @0x020 -> outputs are 0 immediately; after release, load @0x020 returns 0x55AA55AA.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed response latency
// Big-endian byte array; loads extend per req_se, misaligned/reserved sizes answer with rsp_err.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_se,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic       DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        se_q, se_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        acc_rw;
  logic [1:0]  acc_size;
  logic        acc_se;
  logic [8:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_fire;
  logic        acc_err;
  logic [31:0] acc_rdata;
  logic [3:0]  acc_be;
  logic [3:0]  mem_we;
  logic [7:0]  rd_b [4];
  logic [7:0]  wr_b [4];

  // With LATENCY=1 the array is touched on the accept edge, so the live request drives it.
  always_comb begin
    if (state_q == IDLE) begin
      acc_rw    = req_rw;
      acc_size  = req_size;
      acc_se    = req_se;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_rw    = rw_q;
      acc_size  = size_q;
      acc_se    = se_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    acc_fire = 1'b0;
    if (state_q == IDLE && req_valid && DIRECT) begin
      acc_fire = 1'b1;
    end else if (state_q == BUSY && cnt_q == 4'd0) begin
      acc_fire = 1'b1;
    end
  end

  always_comb begin
    case (acc_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = acc_addr[0];
      2'b10:   acc_err = (acc_addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_b[k] = mem[acc_addr + 9'(k)];
    end
  end

  always_comb begin
    acc_rdata = 32'd0;
    if (!acc_rw && !acc_err) begin
      case (acc_size)
        2'b00:   acc_rdata = {{24{acc_se & rd_b[0][7]}}, rd_b[0]};
        2'b01:   acc_rdata = {{16{acc_se & rd_b[0][7]}}, rd_b[0], rd_b[1]};
        2'b10:   acc_rdata = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
        default: acc_rdata = 32'd0;
      endcase
    end
  end

  // Store lanes are indexed from the base address, most significant byte first.
  always_comb begin
    acc_be = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wr_b[k] = 8'd0;
    end
    case (acc_size)
      2'b00: begin
        acc_be  = 4'b0001;
        wr_b[0] = acc_wdata[7:0];
      end
      2'b01: begin
        acc_be  = 4'b0011;
        wr_b[0] = acc_wdata[15:8];
        wr_b[1] = acc_wdata[7:0];
      end
      2'b10: begin
        acc_be  = 4'b1111;
        wr_b[0] = acc_wdata[31:24];
        wr_b[1] = acc_wdata[23:16];
        wr_b[2] = acc_wdata[15:8];
        wr_b[3] = acc_wdata[7:0];
      end
      default: acc_be = 4'b0000;
    endcase
    mem_we = (acc_fire && acc_rw && !acc_err) ? acc_be : 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we[k]) begin
        mem[acc_addr + 9'(k)] <= wr_b[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    size_d      = size_q;
    se_d        = se_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          size_d  = req_size;
          se_d    = req_se;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          if (DIRECT) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = acc_rdata;
            rsp_err_d   = acc_err;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = acc_rdata;
          rsp_err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      size_q      <= 2'b00;
      se_q        <= 1'b0;
      addr_q      <= 9'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      size_q      <= size_d;
      se_q        <= se_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE) && reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
// Expected responses come from a byte-array reference model; a negedge monitor pops and compares.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_se = 1'b0;
  logic [8:0]  req_addr = 9'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.LATENCY(LAT), .DEPTH_BYTES(512)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ref_mem [512];
  int         hold_go = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model(input logic rw, input logic [1:0] size, input logic se,
                                 input logic [8:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          n;
    int          a;
    logic [31:0] v;
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.acc   = 0;
    a = int'(addr);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3 || (a % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (rw) begin
      for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(wdata >> (8 * (n - 1 - k)));
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[a + k]);
      if (se && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic issue(input logic rw, input logic [1:0] size, input logic se, input logic [8:0] addr,
                       input logic [31:0] wdata, input bit use_c, input logic [31:0] c_rd,
                       input logic c_err, input bit toggle);
    exp_t e;
    bit   ok;
    e = model(rw, size, se, addr, wdata);
    if (use_c) begin
      e.rdata = c_rd;
      e.err   = c_err;
    end
    @(posedge clk); #1;
    req_rw = rw; req_size = size; req_se = se; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
    req_rw = 1'($urandom); req_size = 2'($urandom); req_se = 1'($urandom);
    req_addr = 9'($urandom); req_wdata = $urandom;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; req_valid = 1'b0; break; end
      if (toggle) begin
        req_valid = 1'($urandom); req_rw = 1'($urandom); req_addr = 9'($urandom);
        req_wdata = $urandom;
      end
    end
    if (!ok) begin
      fail_now("rsp_timeout");
      exp_q.delete();
    end
  endtask

  // Response acceptance: random back-pressure, or a forced stall of 5 RESP cycles on request.
  initial begin
    int hold_seen = 0;
    int hold_left = 0;
    forever begin
      @(posedge clk); #1;
      if (hold_go != hold_seen) begin hold_seen = hold_go; hold_left = 5; end
      if (hold_left > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) hold_left--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  logic        prev_v = 1'b0;
  bit          was_hs = 1'b0;
  logic [31:0] prev_rd = 32'd0;
  logic        prev_err = 1'b0;
  int          rise_cyc = 0;
  exp_t        me;

  always @(negedge clk) begin
    if (reset) begin
      if (was_hs) begin
        chk("valid_drop", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
      end
      was_hs = 1'b0;
      if (rsp_valid) begin
        chk("ready_low_in_resp", req_ready, 0);
        if (!prev_v) rise_cyc = cyc;
        else begin
          chk("rdata_stable", rsp_rdata, prev_rd);
          chk("err_stable", rsp_err, prev_err);
        end
        prev_rd  = rsp_rdata;
        prev_err = rsp_err;
        if (rsp_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_rsp");
          else begin
            me = exp_q.pop_front();
            chk("rdata", rsp_rdata, me.rdata);
            chk("err", rsp_err, me.err);
            chk("latency", rise_cyc - me.acc, LAT);
          end
          was_hs = 1'b1;
        end
      end
      prev_v = rsp_valid && !rsp_ready;
    end else begin
      was_hs = 1'b0;
      prev_v = 1'b0;
    end
  end

  initial begin
    #2000000;
    fail_now("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_ready", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    issue(1, 2, 0, 9'h010, 32'hDEADBEEF, 1, 32'h0, 0, 0);
    issue(0, 2, 0, 9'h010, 32'h0, 1, 32'hDEADBEEF, 0, 0);
    issue(0, 0, 1, 9'h011, 32'h0, 1, 32'hFFFFFFAD, 0, 1);
    issue(0, 0, 0, 9'h011, 32'h0, 1, 32'h000000AD, 0, 0);
    issue(0, 1, 1, 9'h012, 32'h0, 1, 32'hFFFFBEEF, 0, 1);
    issue(1, 0, 0, 9'h013, 32'h00000012, 1, 32'h0, 0, 0);
    issue(0, 2, 0, 9'h010, 32'h0, 1, 32'hDEADBE12, 0, 0);
    issue(1, 2, 0, 9'h011, 32'h11223344, 1, 32'h0, 1, 0);
    issue(0, 1, 1, 9'h013, 32'h0, 1, 32'h0, 1, 0);
    issue(0, 2, 0, 9'h010, 32'h0, 1, 32'hDEADBE12, 0, 0);
    hold_go++;
    issue(0, 2, 0, 9'h010, 32'h0, 1, 32'hDEADBE12, 0, 1);

    issue(1, 2, 0, 9'h020, 32'h55AA55AA, 1, 32'h0, 0, 0);
    issue(0, 2, 0, 9'h020, 32'h0, 1, 32'h55AA55AA, 0, 0);
    // Store of 0 abandoned by reset while BUSY; the model is deliberately not updated.
    @(posedge clk); #1;
    req_rw = 1'b1; req_size = 2'd2; req_se = 1'b0; req_addr = 9'h020; req_wdata = 32'h0;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout_rst");
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    chk("midrst_err", rsp_err, 0);
    chk("midrst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    issue(0, 2, 0, 9'h020, 32'h0, 1, 32'h55AA55AA, 0, 0);

    for (int i = 0; i < 16; i++) begin
      issue(1, 2, 0, 9'(9'h100 + 4 * i), $urandom, 0, 32'h0, 0, 0);
    end
    for (int i = 0; i < 80; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            9'(9'h100 + $urandom_range(0, 63)), $urandom, 0, 32'h0, 0, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
